// File: rtl/tpu_ctrl_pkg.sv
// rtl/tpu_ctrl_pkg.sv - shared state encoding and timing defaults for the TPU control sequencer
package tpu_ctrl_pkg;

  localparam int RESULT_LAT_DEFAULT = 23;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WWAIT = 3'd1,
    S_WLOAD = 3'd2,
    S_FEED  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } tpu_state_e;

endpackage

// File: rtl/tpu_valid_delay.sv
// rtl/tpu_valid_delay.sv - fixed-depth 1-bit valid delay line with synchronous clear
module tpu_valid_delay #(
  parameter int depth = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_data,
  output logic o_data
);

  logic [depth-1:0] r_sr;

  // Shift the valid bit one stage per cycle; clear drops every in-flight bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else begin
      for (int i = depth - 1; i > 0; i--) begin
        r_sr[i] <= r_sr[i-1];
      end
      r_sr[0] <= i_data;
    end
  end

  assign o_data = r_sr[depth-1];

endmodule

// File: rtl/tpu_ctrl_sequencer.sv
// rtl/tpu_ctrl_sequencer.sv - weight-load / row-feed / result-write sequencer for the systolic array
module tpu_ctrl_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int RESULT_LAT  = RESULT_LAT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic [ADDRESSSIZE-1:0] num_rows,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   ub_read_valid,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   busy,
  output logic                   end_
);

  localparam logic [ADDRESSSIZE-1:0] L_ONE = ADDRESSSIZE'(1);

  tpu_state_e r_state;
  tpu_state_e w_state_nxt;

  logic [ADDRESSSIZE-1:0] r_src;
  logic [ADDRESSSIZE-1:0] r_dst;
  logic [ADDRESSSIZE-1:0] r_rows;
  logic [ADDRESSSIZE-1:0] r_rd_idx;
  logic [ADDRESSSIZE-1:0] r_wr_idx;
  logic [ADDRESSSIZE-1:0] r_ub_addr;
  logic [ADDRESSSIZE-1:0] r_res_addr;
  logic                   r_fre;
  logic                   r_we_rl;
  logic                   r_ub_valid;
  logic                   r_res_we;
  logic                   r_busy;
  logic                   r_end;

  logic [ADDRESSSIZE-1:0] w_rd_idx_nxt;
  logic [ADDRESSSIZE-1:0] w_ub_addr_nxt;
  logic                   w_fre_nxt;
  logic                   w_we_rl_nxt;
  logic                   w_ub_valid_nxt;
  logic                   w_end_nxt;
  logic                   w_latch;
  logic                   w_clear;
  logic                   w_dly;

  // The registered UB issue pulse plus this line plus the write register
  // add up to RESULT_LAT cycles from issue to result write.
  tpu_valid_delay #(
    .depth(RESULT_LAT - 1)
  ) u_valid_delay (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_clear),
    .i_data (r_ub_valid),
    .o_data (w_dly)
  );

  // Next state and next registered outputs; abort overrides everything
  always_comb begin
    w_state_nxt    = r_state;
    w_fre_nxt      = 1'b0;
    w_we_rl_nxt    = 1'b0;
    w_ub_valid_nxt = 1'b0;
    w_ub_addr_nxt  = r_ub_addr;
    w_rd_idx_nxt   = r_rd_idx;
    w_end_nxt      = 1'b0;
    w_latch        = 1'b0;
    w_clear        = abort && (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch     = 1'b1;
          w_state_nxt = S_WWAIT;
        end
      end
      S_WWAIT: begin
        if (!fifo_empty) begin
          w_fre_nxt   = 1'b1;
          w_state_nxt = S_WLOAD;
        end
      end
      S_WLOAD: begin
        w_we_rl_nxt = 1'b1;
        w_state_nxt = (r_rows == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        w_ub_valid_nxt = 1'b1;
        w_ub_addr_nxt  = r_src + r_rd_idx;
        w_rd_idx_nxt   = r_rd_idx + L_ONE;
        if (r_rd_idx == r_rows - L_ONE) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as the final row's result is being written; nothing else is in flight
        if (w_dly && (r_wr_idx == r_rows - L_ONE)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_end_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_clear) begin
      w_state_nxt    = S_IDLE;
      w_fre_nxt      = 1'b0;
      w_we_rl_nxt    = 1'b0;
      w_ub_valid_nxt = 1'b0;
      w_end_nxt      = 1'b0;
    end
  end

  // State, job parameters, read-side counter and control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_rows     <= '0;
      r_rd_idx   <= '0;
      r_ub_addr  <= '0;
      r_fre      <= 1'b0;
      r_we_rl    <= 1'b0;
      r_ub_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ub_addr  <= w_ub_addr_nxt;
      r_fre      <= w_fre_nxt;
      r_we_rl    <= w_we_rl_nxt;
      r_ub_valid <= w_ub_valid_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_end      <= w_end_nxt;
      if (w_latch) begin
        r_src    <= src_base;
        r_dst    <= dst_base;
        r_rows   <= num_rows;
        r_rd_idx <= '0;
      end else begin
        r_rd_idx <= w_rd_idx_nxt;
      end
    end
  end

  // Result-side writes: one per delayed valid, addresses counted from dst_base
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_we   <= 1'b0;
      r_res_addr <= '0;
      r_wr_idx   <= '0;
    end else if (w_clear) begin
      r_res_we <= 1'b0;
    end else begin
      r_res_we <= w_dly;
      if (w_dly) begin
        r_res_addr <= r_dst + r_wr_idx;
        r_wr_idx   <= r_wr_idx + L_ONE;
      end
      if (w_latch) begin
        r_wr_idx <= '0;
      end
    end
  end

  assign fifo_read_enable = r_fre;
  assign we_rl            = r_we_rl;
  assign ub_address       = r_ub_addr;
  assign ub_read_valid    = r_ub_valid;
  assign res_write_enable = r_res_we;
  assign res_address      = r_res_addr;
  assign busy             = r_busy;
  assign end_             = r_end;

endmodule

// File: tb/tb_tpu_ctrl_sequencer.sv
// tb/tb_tpu_ctrl_sequencer.sv - directed self-checking bench for tpu_ctrl_sequencer
module tb_tpu_ctrl_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [9:0] src_base;
  logic [9:0] dst_base;
  logic [9:0] num_rows;
  logic       fifo_empty;
  logic       fifo_read_enable;
  logic       we_rl;
  logic [9:0] ub_address;
  logic       ub_read_valid;
  logic       res_write_enable;
  logic [9:0] res_address;
  logic       busy;
  logic       end_;

  int checks = 0;
  int errors = 0;

  logic [25:0] obs [0:63];
  logic [25:0] exp_v;
  logic [9:0]  puba;
  logic [9:0]  pra;

  tpu_ctrl_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .src_base        (src_base),
    .dst_base        (dst_base),
    .num_rows        (num_rows),
    .fifo_empty      (fifo_empty),
    .fifo_read_enable(fifo_read_enable),
    .we_rl           (we_rl),
    .ub_address      (ub_address),
    .ub_read_valid   (ub_read_valid),
    .res_write_enable(res_write_enable),
    .res_address     (res_address),
    .busy            (busy),
    .end_            (end_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] snap();
    return {fifo_read_enable, we_rl, ub_read_valid, ub_address,
            res_write_enable, res_address, busy, end_};
  endfunction

  // Expected outputs at cycle c (cycle 0 = edge that samples start)
  function automatic logic [25:0] exp_vec(int c, int src, int dst, int rows, int e, int ab,
                                          logic [9:0] pu, logic [9:0] pr);
    int t_rd  = 3 + e;
    int t_wr  = 26 + e;
    int t_end = (rows == 0) ? 3 + e : 26 + e + rows;
    int cc    = c;
    logic fre, we, ubv, rwe, bsy, en;
    logic [9:0] uba, ra;
    if (ab >= 0 && c > ab) cc = ab;
    fre = (c == 1 + e);
    we  = (c == 2 + e);
    ubv = (c >= t_rd) && (c < t_rd + rows);
    rwe = (c >= t_wr) && (c < t_wr + rows);
    en  = (c == t_end);
    bsy = (c < t_end);
    if (rows == 0 || cc < t_rd) uba = pu;
    else uba = 10'(src + ((cc < t_rd + rows) ? cc - t_rd : rows - 1));
    if (rows == 0 || cc < t_wr) ra = pr;
    else ra = 10'(dst + ((cc < t_wr + rows) ? cc - t_wr : rows - 1));
    if (ab >= 0 && c > ab) begin
      fre = 1'b0; we = 1'b0; ubv = 1'b0; rwe = 1'b0; en = 1'b0; bsy = 1'b0;
    end
    return {fre, we, ubv, uba, rwe, ra, bsy, en};
  endfunction

  // Launch a job and record outputs for ncyc cycles
  task automatic run_job(input int src, input int dst, input int rows, input int e,
                         input int ab, input int restart_at, input int ncyc);
    src_base   = 10'(src);
    dst_base   = 10'(dst);
    num_rows   = 10'(rows);
    fifo_empty = (e > 0);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      obs[k]     = snap();
      fifo_empty = (k < e);
      abort      = (k == ab);
      if (k == restart_at) begin
        start    = 1'b1;
        src_base = 10'h155;
        dst_base = 10'h2AA;
        num_rows = 10'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start      = 1'b0;
    abort      = 1'b0;
    fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (snap() !== 26'h0) begin
      errors++;
      $display("FAIL reset: outputs got %h expected %h", snap(), 26'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    puba = 10'h000;
    pra  = 10'h000;
  endtask

  task automatic test_basic();
    run_job('h010, 'h200, 8, 0, -1, 12, 40);
    for (int c = 0; c < 40; c++) begin
      exp_v = exp_vec(c, 'h010, 'h200, 8, 0, -1, puba, pra);
      checks++;
      if (obs[c] !== exp_v) begin
        errors++;
        $display("FAIL basic cycle %0d: got %h expected %h", c, obs[c], exp_v);
      end
    end
    puba = 10'h017;
    pra  = 10'h207;
  endtask

  task automatic test_fifo_wait();
    run_job('h020, 'h100, 4, 5, -1, -1, 40);
    for (int c = 0; c < 40; c++) begin
      exp_v = exp_vec(c, 'h020, 'h100, 4, 5, -1, puba, pra);
      checks++;
      if (obs[c] !== exp_v) begin
        errors++;
        $display("FAIL fifo_wait cycle %0d: got %h expected %h", c, obs[c], exp_v);
      end
    end
    puba = 10'h023;
    pra  = 10'h103;
  endtask

  task automatic test_wrap();
    run_job('h3FE, 'h3FF, 3, 0, -1, -1, 33);
    for (int c = 0; c < 33; c++) begin
      exp_v = exp_vec(c, 'h3FE, 'h3FF, 3, 0, -1, puba, pra);
      checks++;
      if (obs[c] !== exp_v) begin
        errors++;
        $display("FAIL wrap cycle %0d: got %h expected %h", c, obs[c], exp_v);
      end
    end
    puba = 10'h000;
    pra  = 10'h001;
  endtask

  task automatic test_zero_rows();
    run_job('h055, 'h066, 0, 0, -1, -1, 8);
    for (int c = 0; c < 8; c++) begin
      exp_v = exp_vec(c, 'h055, 'h066, 0, 0, -1, puba, pra);
      checks++;
      if (obs[c] !== exp_v) begin
        errors++;
        $display("FAIL zero_rows cycle %0d: got %h expected %h", c, obs[c], exp_v);
      end
    end
  endtask

  task automatic test_abort();
    run_job('h010, 'h200, 8, 0, 15, -1, 40);
    for (int c = 0; c < 40; c++) begin
      exp_v = exp_vec(c, 'h010, 'h200, 8, 0, 15, puba, pra);
      checks++;
      if (obs[c] !== exp_v) begin
        errors++;
        $display("FAIL abort cycle %0d: got %h expected %h", c, obs[c], exp_v);
      end
    end
    puba = 10'h017;
    run_job('h040, 'h080, 2, 0, -1, -1, 32);
    for (int c = 0; c < 32; c++) begin
      exp_v = exp_vec(c, 'h040, 'h080, 2, 0, -1, puba, pra);
      checks++;
      if (obs[c] !== exp_v) begin
        errors++;
        $display("FAIL after_abort cycle %0d: got %h expected %h", c, obs[c], exp_v);
      end
    end
    puba = 10'h041;
    pra  = 10'h081;
  endtask

  task automatic test_reset_mid_job();
    run_job('h010, 'h200, 8, 0, -1, -1, 21);
    for (int c = 0; c < 21; c++) begin
      exp_v = exp_vec(c, 'h010, 'h200, 8, 0, -1, puba, pra);
      checks++;
      if (obs[c] !== exp_v) begin
        errors++;
        $display("FAIL pre_reset cycle %0d: got %h expected %h", c, obs[c], exp_v);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (snap() !== 26'h0) begin
      errors++;
      $display("FAIL async_reset: outputs got %h expected %h", snap(), 26'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      checks++;
      if (snap() !== 26'h0) begin
        errors++;
        $display("FAIL post_reset cycle %0d: got %h expected %h", c, snap(), 26'h0);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    src_base   = 10'h0;
    dst_base   = 10'h0;
    num_rows   = 10'h0;
    fifo_empty = 1'b0;
    test_reset();
    test_basic();
    test_fifo_wait();
    test_wrap();
    test_zero_rows();
    test_abort();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_ctrl_sequencer.md
TPU_CTRL_SEQUENCER -- requirements
Module: tpu_ctrl_sequencer

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 10: UB and result-SRAM address width.
REQ-002 SHALL have parameter RESULT_LAT, default 23: cycles from a UB read issue to the matching aligned result row.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to run one job.
REQ-006 SHALL have port abort, input, 1 bit: synchronous job cancel.
REQ-007 SHALL have port src_base, input, ADDRESSSIZE bits: first UB address of the input rows.
REQ-008 SHALL have port dst_base, input, ADDRESSSIZE bits: first result-SRAM address.
REQ-009 SHALL have port num_rows, input, ADDRESSSIZE bits: number of input rows to stream.
REQ-010 SHALL have port fifo_empty, input, 1 bit: weight FIFO empty flag.
REQ-011 SHALL have port fifo_read_enable, output, 1 bit: pops one weight tile.
REQ-012 SHALL have port we_rl, output, 1 bit: systolic-array weight reload.
REQ-013 SHALL have port ub_address, output, ADDRESSSIZE bits: UB read address.
REQ-014 SHALL have port ub_read_valid, output, 1 bit: ub_address is a live issue.
REQ-015 SHALL have port res_write_enable, output, 1 bit: result-SRAM write strobe.
REQ-016 SHALL have port res_address, output, ADDRESSSIZE bits: result-SRAM write address.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port end_, output, 1 bit: one-cycle job-done pulse.

Function
REQ-019 SHALL implement FSM states IDLE, WWAIT, WLOAD, FEED, DRAIN, DONE; all outputs SHALL be registered.
REQ-020 In IDLE with start=1, SHALL latch src_base, dst_base and num_rows, then enter WWAIT; start in any other state SHALL be ignored.
REQ-021 In WWAIT, SHALL stay while fifo_empty=1 (no timeout); on the first cycle with fifo_empty=0, SHALL assert fifo_read_enable for exactly one cycle and enter WLOAD.
REQ-022 In WLOAD, SHALL assert we_rl for exactly one cycle, then enter FEED, or enter DONE directly if the latched num_rows=0.
REQ-023 In FEED, SHALL drive ub_read_valid=1 with ub_address=src_base+i for i=0..num_rows-1 on consecutive cycles, then enter DRAIN.
REQ-024 SHALL delay each ub_read_valid by exactly RESULT_LAT cycles through a shift register; the k-th delayed pulse SHALL drive res_write_enable=1 with res_address=dst_base+k.
REQ-025 In DRAIN, SHALL stay until the delay line holds no valid bits and the last write has been issued, then enter DONE.
REQ-026 In DONE, SHALL assert end_ for one cycle, then return to IDLE.
REQ-027 All address sums SHALL wrap modulo 2^ADDRESSSIZE.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, clear the delay line, and suppress end_; abort SHALL take priority over all other transitions.
REQ-029 Outside their active cycles, fifo_read_enable, we_rl, ub_read_valid, res_write_enable and end_ SHALL be 0, and the address outputs SHALL hold their last value.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, clear the delay line and row counters, and drive all outputs to 0 (addresses included); reset mid-job SHALL discard the job.

Structure
REQ-031 The FSM state encoding and the RESULT_LAT default SHALL live in shared package tpu_ctrl_pkg.
REQ-032 The delay line SHALL be a sub-module tpu_valid_delay (parameter depth, 1-bit data in/out, synchronous clear).

Verification
REQ-033 Scenario: src_base=0x010, dst_base=0x200, num_rows=8, FIFO non-empty -> fifo_read_enable at cycle 1, we_rl at cycle 2, ub_address 0x010..0x017 at cycles 3..10, res writes 0x200..0x207 at cycles 26..33, end_ at cycle 34 (cycle 0 = start).
REQ-034 Scenario: fifo_empty=1 for 5 cycles after start -> busy=1, no pops; pop on the first cycle with fifo_empty=0; the remaining timing shifts by 5.
REQ-035 Scenario: src_base=0x3FE, dst_base=0x3FF, num_rows=3 -> UB reads 0x3FE,0x3FF,0x000; writes 0x3FF,0x000,0x001.
REQ-036 Scenario: num_rows=0 -> one pop, one we_rl, no UB reads or writes, end_ 3 cycles after start.
REQ-037 Scenario: abort at cycle 15 of the REQ-033 job -> IDLE at cycle 16, no further writes, no end_; a new start then runs normally.
REQ-038 Scenario: rst pulse during DRAIN -> outputs 0 asynchronously; start asserted while busy is ignored.
